// File: rtl/des_pkg.sv
// DES key-schedule tables and bit-permutation helpers shared by the subkey
// generator and the round datapath.
package des_pkg;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  // PC-1 in DES bit numbering (1 = key MSB); first 28 entries form C, last 28 form D
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2 in DES bit numbering over the 56-bit {C,D}
  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    logic [5:0]  src;
    logic [5:0]  dst;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      src = 6'(64 - PC1_TBL[i]);
      dst = 6'(55 - i);
      r[dst] = k[src];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [5:0]  src;
    logic [5:0]  dst;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      src = 6'(56 - PC2_TBL[i]);
      dst = 6'(47 - i);
      r[dst] = cd[src];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_subkey_gen.sv
// Streams DES round subkeys K1..K16 (encrypt) or K16..K1 (decrypt) one per
// valid/ready handshake, rotating C/D in place instead of storing all subkeys.
module des_subkey_gen
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  key_num,
  output logic        busy,
  output logic        done
);

  state_t      state;
  state_t      next_state;
  logic [27:0] c;
  logic [27:0] d;
  logic        mode;
  logic [55:0] cd_init;
  logic        handshake;
  logic        last;
  logic [3:0]  next_num;

  assign cd_init   = pc1(key);
  assign handshake = (state == STREAM) && subkey_ready;
  assign last      = mode ? (key_num == 4'd0) : (key_num == 4'd15);
  assign next_num  = key_num + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = STREAM;
      STREAM:  if (handshake && last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == STREAM);
    subkey_valid = (state == STREAM);
  end

  // Encrypt walks forward rotating left by the upcoming shift; decrypt undoes
  // the current shift, which lands on C0/D0 for K16 without pre-rotation.
  always_ff @(posedge clk) begin
    if (rst) begin
      c       <= '0;
      d       <= '0;
      key_num <= '0;
      mode    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          mode <= decrypt;
          if (decrypt) begin
            c       <= cd_init[55:28];
            d       <= cd_init[27:0];
            key_num <= 4'd15;
          end else begin
            c       <= rotl28(cd_init[55:28], SHIFT[0]);
            d       <= rotl28(cd_init[27:0], SHIFT[0]);
            key_num <= 4'd0;
          end
        end
      end else if (handshake) begin
        if (last) begin
          done <= 1'b1;
        end else if (!mode) begin
          c       <= rotl28(c, SHIFT[next_num]);
          d       <= rotl28(d, SHIFT[next_num]);
          key_num <= next_num;
        end else begin
          c       <= rotr28(c, SHIFT[key_num]);
          d       <= rotr28(d, SHIFT[key_num]);
          key_num <= key_num - 4'd1;
        end
      end
    end
  end

  assign subkey = pc2({c, d});

endmodule
